// File: rtl/matrix_key_scan_if.sv
// Keypad-side signal bundle for matrix_key_scan: row sense in, column drive and
// confirmed-key outputs. slave is the scanner side, master the keypad/consumer side.
interface matrix_key_scan_if;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] onehot;
   logic        key_valid;
   logic        key_down;

   modport slave  (input  row_in, output col_out, onehot, key_valid, key_down);
   modport master (output row_in, input  col_out, onehot, key_valid, key_down);
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner: steps one low column per tick, debounces press and release on
// the candidate row, publishes the confirmed key as a held one-hot word.
module matrix_key_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int DB_TICKS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   matrix_key_scan_if.slave kp
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DB_TICKS + 1);
   // The detection tick counts as the first stable tick, so the debounce counter
   // only needs to see DB_TICKS-1 more (but at least one).
   localparam logic [CW-1:0] DB_LAST = (DB_TICKS > 1) ? CW'(DB_TICKS - 1) : CW'(1);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

   state_t          r_state, w_state_nx;
   logic [DW-1:0]   r_div;
   logic [1:0]      r_col, w_col_nx;
   logic [1:0]      r_cand_row, w_cand_row_nx;
   logic [1:0]      r_cand_col, w_cand_col_nx;
   logic [CW-1:0]   r_db_cnt, w_db_nx;
   logic [15:0]     r_onehot, w_onehot_nx;
   logic            r_key_valid, w_kv_nx;
   logic            r_key_down, w_kd_nx;
   logic [3:0]      r_row_m, r_row_s;

   logic            w_tick;
   logic            w_row_lvl;
   logic [1:0]      w_low_row;
   logic [CW-1:0]   w_db_inc;

   assign w_tick    = (r_div == DW'(SCAN_DIV - 1));
   assign w_row_lvl = r_row_s[r_cand_row];
   assign w_db_inc  = r_db_cnt + 1'b1;

   always_comb begin
      w_low_row = 2'd0;
      if (!r_row_s[0])      w_low_row = 2'd0;
      else if (!r_row_s[1]) w_low_row = 2'd1;
      else if (!r_row_s[2]) w_low_row = 2'd2;
      else                  w_low_row = 2'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_m <= 4'hF;
         r_row_s <= 4'hF;
         r_div   <= '0;
      end else begin
         r_row_m <= kp.row_in;
         r_row_s <= r_row_m;
         r_div   <= w_tick ? '0 : r_div + 1'b1;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_col_nx      = r_col;
      w_cand_row_nx = r_cand_row;
      w_cand_col_nx = r_cand_col;
      w_db_nx       = r_db_cnt;
      w_onehot_nx   = r_onehot;
      w_kv_nx       = 1'b0;
      w_kd_nx       = r_key_down;
      if (w_tick) begin
         case (r_state)
            S_SCAN: begin
               if (r_row_s == 4'hF) begin
                  w_col_nx = r_col + 2'd1;
               end else begin
                  w_cand_row_nx = w_low_row;
                  w_cand_col_nx = r_col;
                  w_db_nx       = '0;
                  w_state_nx    = S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (!w_row_lvl) begin
                  w_db_nx = w_db_inc;
                  if (w_db_inc >= DB_LAST) begin
                     w_onehot_nx = 16'd1 << {r_cand_row, r_cand_col};
                     w_kv_nx     = 1'b1;
                     w_kd_nx     = 1'b1;
                     w_state_nx  = S_HELD;
                  end
               end else begin
                  w_db_nx    = '0;
                  w_col_nx   = r_col + 2'd1;
                  w_state_nx = S_SCAN;
               end
            end
            S_HELD: begin
               if (w_row_lvl) begin
                  w_db_nx = '0;
                  // With single-tick debounce the first high tick is the release.
                  if (DB_TICKS == 1) begin
                     w_kd_nx    = 1'b0;
                     w_col_nx   = r_col + 2'd1;
                     w_state_nx = S_SCAN;
                  end else begin
                     w_state_nx = S_RELEASE;
                  end
               end
            end
            default: begin
               if (w_row_lvl) begin
                  w_db_nx = w_db_inc;
                  if (w_db_inc >= DB_LAST) begin
                     w_kd_nx    = 1'b0;
                     w_col_nx   = r_col + 2'd1;
                     w_state_nx = S_SCAN;
                  end
               end else begin
                  w_state_nx = S_HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_SCAN;
         r_col       <= 2'd0;
         r_cand_row  <= 2'd0;
         r_cand_col  <= 2'd0;
         r_db_cnt    <= '0;
         r_onehot    <= 16'h0000;
         r_key_valid <= 1'b0;
         r_key_down  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_col       <= w_col_nx;
         r_cand_row  <= w_cand_row_nx;
         r_cand_col  <= w_cand_col_nx;
         r_db_cnt    <= w_db_nx;
         r_onehot    <= w_onehot_nx;
         r_key_valid <= w_kv_nx;
         r_key_down  <= w_kd_nx;
      end
   end

   assign kp.col_out   = ~(4'b0001 << r_col);
   assign kp.onehot    = r_onehot;
   assign kp.key_valid = r_key_valid;
   assign kp.key_down  = r_key_down;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Directed bench for matrix_key_scan (SCAN_DIV=4, DB_TICKS=3) with a keypad model
// that pulls the selected rows low only while its column is driven.
module tb_matrix_key_scan;

   logic       clk;
   logic       rst_n;
   logic       key_en;
   logic [1:0] key_col;
   logic [3:0] key_rows;
   int         n_total;
   int         n_bad;
   int         kv_cnt;

   matrix_key_scan_if kp_if ();

   matrix_key_scan #(.SCAN_DIV(4), .DB_TICKS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp_if.slave)
   );

   assign kp_if.row_in = (key_en && !kp_if.col_out[key_col]) ? key_rows : 4'hF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (kp_if.key_valid === 1'b1) kv_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      kv_cnt   = 0;
      rst_n    = 1'b0;
      key_en   = 1'b0;
      key_col  = 2'd0;
      key_rows = 4'hF;

      cyc(3);
      chk("rst_col", 32'(kp_if.col_out), 32'hE);
      chk("rst_onehot", 32'(kp_if.onehot), 32'h0);
      chk("rst_kv", 32'(kp_if.key_valid), 32'h0);
      chk("rst_kd", 32'(kp_if.key_down), 32'h0);
      rst_n = 1'b1;

      // idle scan: one column step every 4 clk
      cyc(3);  chk("idle_col_p3", 32'(kp_if.col_out), 32'hE);
      cyc(1);  chk("idle_col_p4", 32'(kp_if.col_out), 32'hD);
      cyc(4);  chk("idle_col_p8", 32'(kp_if.col_out), 32'hB);
      cyc(4);  chk("idle_col_p12", 32'(kp_if.col_out), 32'h7);
      cyc(4);  chk("idle_col_p16", 32'(kp_if.col_out), 32'hE);
      chk("idle_onehot", 32'(kp_if.onehot), 32'h0);
      chk("idle_kv_cnt", 32'(kv_cnt), 32'd0);

      // bounce: row 2 at col 1, low for detection + one tick, then high
      key_col  = 2'd1;
      key_rows = 4'b1011;
      key_en   = 1'b1;
      cyc(12); chk("bounce_frozen", 32'(kp_if.col_out), 32'hD);
      key_en = 1'b0;
      cyc(4);  chk("bounce_col", 32'(kp_if.col_out), 32'hB);
      chk("bounce_kv_cnt", 32'(kv_cnt), 32'd0);
      chk("bounce_onehot", 32'(kp_if.onehot), 32'h0);

      // clean press of row 2 / col 1
      key_en = 1'b1;
      cyc(23); chk("press_pre_kv", 32'(kp_if.key_valid), 32'h0);
      chk("press_pre_kd", 32'(kp_if.key_down), 32'h0);
      chk("press_pre_col", 32'(kp_if.col_out), 32'hD);
      cyc(1);  chk("press_kv", 32'(kp_if.key_valid), 32'h1);
      chk("press_onehot", 32'(kp_if.onehot), 32'h0200);
      chk("press_kd", 32'(kp_if.key_down), 32'h1);
      cyc(1);  chk("press_kv_pulse", 32'(kp_if.key_valid), 32'h0);
      chk("press_held_col", 32'(kp_if.col_out), 32'hD);

      // release bounce: one high tick, then low again
      key_en = 1'b0;
      cyc(3);  chk("relb_kd_a", 32'(kp_if.key_down), 32'h1);
      key_en = 1'b1;
      cyc(4);  chk("relb_kd_b", 32'(kp_if.key_down), 32'h1);
      key_en = 1'b0;
      cyc(11); chk("rel_pre_kd", 32'(kp_if.key_down), 32'h1);
      cyc(1);  chk("rel_kd", 32'(kp_if.key_down), 32'h0);
      chk("rel_col", 32'(kp_if.col_out), 32'hB);
      chk("rel_onehot", 32'(kp_if.onehot), 32'h0200);
      chk("rel_kv_cnt", 32'(kv_cnt), 32'd1);

      // rows 1 and 3 low at col 0: lowest row wins
      key_col  = 2'd0;
      key_rows = 4'b0101;
      key_en   = 1'b1;
      cyc(19); chk("multi_pre_kv", 32'(kp_if.key_valid), 32'h0);
      cyc(1);  chk("multi_kv", 32'(kp_if.key_valid), 32'h1);
      chk("multi_onehot", 32'(kp_if.onehot), 32'h0010);
      chk("multi_col", 32'(kp_if.col_out), 32'hE);
      cyc(8);  chk("multi_kv_cnt", 32'(kv_cnt), 32'd2);
      chk("multi_kd", 32'(kp_if.key_down), 32'h1);

      // asynchronous reset while a key is held
      rst_n = 1'b0;
      #1;
      chk("mrst_col", 32'(kp_if.col_out), 32'hE);
      chk("mrst_onehot", 32'(kp_if.onehot), 32'h0);
      chk("mrst_kd", 32'(kp_if.key_down), 32'h0);
      chk("mrst_kv", 32'(kp_if.key_valid), 32'h0);
      key_en = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(12); chk("mrst_exit_col", 32'(kp_if.col_out), 32'h7);
      chk("mrst_exit_kv_cnt", 32'(kv_cnt), 32'd2);
      chk("mrst_exit_onehot", 32'(kp_if.onehot), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
